// File: rtl/nvme_cq_pkg.sv
// Shared types and constants for the NVMe completion-queue scheduler.
//   cq_state_e : posting FSM state (idle / write in flight)
//   CQE_BYTES  : size of one completion queue entry in host memory
//   PHASE_BIT  : bit position of the phase tag inside a 128-bit entry (DW3 bit 16)
//   cq_ptr_t   : head/tail pointer type, wide enough for any doorbell value
//   ptr_inc    : modulo-depth pointer increment
package nvme_cq_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StWrite
    } cq_state_e;

    localparam int unsigned CQE_BYTES = 16;
    localparam int unsigned PHASE_BIT = 112;

    typedef logic [31:0] cq_ptr_t;

    function automatic cq_ptr_t ptr_inc(input cq_ptr_t p, input int unsigned depth);
        return (p == cq_ptr_t'(depth - 1)) ? '0 : p + 32'd1;
    endfunction

endpackage

// File: rtl/nvme_rr_arbiter.sv
// Round-robin arbiter with one-hot grant.
//   req       : request vector
//   last      : index of the previous winner; search starts at last+1 and wraps
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : binary index of the granted requester
//   any       : at least one request is granted
module nvme_rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    // k is the distance from the previous winner; the first requester found at the
    // smallest distance wins. Matching i against last+k or last+k-N covers the wrap.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!any && req[i] && ((32'(last) + k == i) || (32'(last) + k == i + N))) begin
                    grant[i]  = 1'b1;
                    grant_idx = IDX_W'(i);
                    any       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/nvme_cq_scheduler.sv
// Completion-queue posting scheduler.
// Arbitrates per-queue completion requesters round-robin, posts one 16-byte entry at a time
// to the PCIe posted-write path, and owns each queue's tail pointer and phase tag. Head
// pointers come from host doorbells.
//   clk, reset                  : clock, asynchronous active-high reset
//   cq_enable                   : per-queue enable; disabling clears the queue
//   cq_base_addr                : per-queue host base address (64 bits each)
//   req_valid/req_entry         : per-queue completion request and 128-bit entry
//   req_ready                   : one-hot pulse, entry captured this cycle
//   cq_write_req/ack/data/addr/id : PCIe write handshake, held stable until ack
//   cq_dbell_valid/id/ptr       : head doorbell; cq_dbell_ack / dbell_err one cycle later
//   cq_full, cq_empty           : per-queue status from registered pointers
//   cq_irq                      : per-queue pulse the cycle after an entry is written
module nvme_cq_scheduler
    import nvme_cq_pkg::*;
#(
    parameter int unsigned CQ_COUNT = 4,
    parameter int unsigned CQ_DEPTH = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CQ_COUNT-1:0]     cq_enable,
    input  logic [64*CQ_COUNT-1:0]  cq_base_addr,
    input  logic [CQ_COUNT-1:0]     req_valid,
    input  logic [128*CQ_COUNT-1:0] req_entry,
    output logic [CQ_COUNT-1:0]     req_ready,
    output logic                    cq_write_req,
    input  logic                    cq_write_ack,
    output logic [127:0]            cq_write_data,
    output logic [63:0]             cq_write_addr,
    output logic [31:0]             cq_write_id,
    input  logic                    cq_dbell_valid,
    input  logic [31:0]             cq_dbell_id,
    input  logic [31:0]             cq_dbell_ptr,
    output logic                    cq_dbell_ack,
    output logic                    dbell_err,
    output logic [CQ_COUNT-1:0]     cq_full,
    output logic [CQ_COUNT-1:0]     cq_empty,
    output logic [CQ_COUNT-1:0]     cq_irq
);

    localparam int unsigned IDX_W = (CQ_COUNT > 1) ? $clog2(CQ_COUNT) : 1;

    cq_state_e           state_q;
    cq_ptr_t             tail_q [CQ_COUNT];
    cq_ptr_t             head_q [CQ_COUNT];
    logic [CQ_COUNT-1:0] phase_q;
    logic [CQ_COUNT-1:0] gnt_oh_q;
    logic [CQ_COUNT-1:0] irq_q;
    logic [IDX_W-1:0]    rr_q;
    logic [IDX_W-1:0]    gnt_idx_q;
    logic                aborted_q;
    logic                dbell_ack_q;
    logic                dbell_err_q;
    logic [127:0]        data_q;
    logic [63:0]         addr_q;

    logic [CQ_COUNT-1:0] eligible;
    logic [CQ_COUNT-1:0] grant;
    logic [CQ_COUNT-1:0] dbell_hit;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_any;
    logic [127:0]        sel_entry;
    logic [63:0]         sel_addr;
    logic                gnt_en;

    always_comb begin
        cq_full   = '0;
        cq_empty  = '0;
        eligible  = '0;
        dbell_hit = '0;
        for (int unsigned i = 0; i < CQ_COUNT; i++) begin
            cq_full[i]   = (ptr_inc(tail_q[i], CQ_DEPTH) == head_q[i]);
            cq_empty[i]  = (tail_q[i] == head_q[i]);
            eligible[i]  = cq_enable[i] & req_valid[i] & ~cq_full[i];
            dbell_hit[i] = cq_dbell_valid && (cq_dbell_id == 32'(i)) &&
                           (cq_dbell_ptr < CQ_DEPTH) && cq_enable[i];
        end
    end

    nvme_rr_arbiter #(
        .N (CQ_COUNT)
    ) u_arb (
        .req       (eligible),
        .last      (rr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    assign req_ready = (state_q == StIdle) ? grant : '0;

    // Entry and address of the current winner; the phase tag is stamped at capture time.
    always_comb begin
        sel_entry = '0;
        sel_addr  = '0;
        for (int unsigned i = 0; i < CQ_COUNT; i++) begin
            if (grant[i]) begin
                sel_entry            = req_entry[128*i +: 128];
                sel_entry[PHASE_BIT] = phase_q[i];
                sel_addr             = cq_base_addr[64*i +: 64] +
                                       64'(tail_q[i]) * 64'(CQE_BYTES);
            end
        end
    end

    assign gnt_en = |(cq_enable & gnt_oh_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            for (int unsigned i = 0; i < CQ_COUNT; i++) begin
                tail_q[i] <= '0;
                head_q[i] <= '0;
            end
            phase_q     <= '1;
            gnt_oh_q    <= '0;
            irq_q       <= '0;
            // Previous winner = last queue, so the first grant after reset goes to queue 0.
            rr_q        <= IDX_W'(CQ_COUNT - 1);
            gnt_idx_q   <= '0;
            aborted_q   <= 1'b0;
            dbell_ack_q <= 1'b0;
            dbell_err_q <= 1'b0;
            data_q      <= '0;
            addr_q      <= '0;
        end else begin
            irq_q       <= '0;
            dbell_ack_q <= cq_dbell_valid;
            dbell_err_q <= cq_dbell_valid & ~(|dbell_hit);
            for (int unsigned i = 0; i < CQ_COUNT; i++) begin
                if (dbell_hit[i]) begin
                    head_q[i] <= cq_dbell_ptr;
                end
            end

            case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        state_q   <= StWrite;
                        gnt_oh_q  <= grant;
                        gnt_idx_q <= grant_idx;
                        rr_q      <= grant_idx;
                        aborted_q <= 1'b0;
                        data_q    <= sel_entry;
                        addr_q    <= sel_addr;
                    end
                end
                StWrite: begin
                    // A queue disabled at any point while its write is in flight loses
                    // the tail advance and interrupt, even if re-enabled before the ack.
                    if (!gnt_en) begin
                        aborted_q <= 1'b1;
                    end
                    if (cq_write_ack) begin
                        state_q <= StIdle;
                        if (gnt_en && !aborted_q) begin
                            irq_q <= gnt_oh_q;
                            for (int unsigned i = 0; i < CQ_COUNT; i++) begin
                                if (gnt_oh_q[i]) begin
                                    tail_q[i] <= ptr_inc(tail_q[i], CQ_DEPTH);
                                    if (tail_q[i] == cq_ptr_t'(CQ_DEPTH - 1)) begin
                                        phase_q[i] <= ~phase_q[i];
                                    end
                                end
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Disabled queues are held cleared, except the one whose write is still in flight.
            for (int unsigned i = 0; i < CQ_COUNT; i++) begin
                if (!cq_enable[i] && !((state_q == StWrite) && gnt_oh_q[i])) begin
                    tail_q[i]  <= '0;
                    head_q[i]  <= '0;
                    phase_q[i] <= 1'b1;
                end
            end
        end
    end

    assign cq_write_req  = (state_q == StWrite);
    assign cq_write_data = data_q;
    assign cq_write_addr = addr_q;
    assign cq_write_id   = 32'(gnt_idx_q);
    assign cq_dbell_ack  = dbell_ack_q;
    assign dbell_err     = dbell_err_q;
    assign cq_irq        = irq_q;

endmodule

// File: tb/tb_nvme_cq_scheduler.sv
// Directed bench for nvme_cq_scheduler with 4 queues of depth 4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_nvme_cq_scheduler;

    localparam int unsigned N = 4;
    localparam int unsigned D = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     cq_enable;
    logic [64*N-1:0]  cq_base_addr;
    logic [N-1:0]     req_valid;
    logic [128*N-1:0] req_entry;
    logic [N-1:0]     req_ready;
    logic             cq_write_req;
    logic             cq_write_ack;
    logic [127:0]     cq_write_data;
    logic [63:0]      cq_write_addr;
    logic [31:0]      cq_write_id;
    logic             cq_dbell_valid;
    logic [31:0]      cq_dbell_id;
    logic [31:0]      cq_dbell_ptr;
    logic             cq_dbell_ack;
    logic             dbell_err;
    logic [N-1:0]     cq_full;
    logic [N-1:0]     cq_empty;
    logic [N-1:0]     cq_irq;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    logic [95:0] low_bits = 96'h0000_1111_2222_3333_4444_5555;

    nvme_cq_scheduler #(
        .CQ_COUNT (N),
        .CQ_DEPTH (D)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cq_enable      (cq_enable),
        .cq_base_addr   (cq_base_addr),
        .req_valid      (req_valid),
        .req_entry      (req_entry),
        .req_ready      (req_ready),
        .cq_write_req   (cq_write_req),
        .cq_write_ack   (cq_write_ack),
        .cq_write_data  (cq_write_data),
        .cq_write_addr  (cq_write_addr),
        .cq_write_id    (cq_write_id),
        .cq_dbell_valid (cq_dbell_valid),
        .cq_dbell_id    (cq_dbell_id),
        .cq_dbell_ptr   (cq_dbell_ptr),
        .cq_dbell_ack   (cq_dbell_ack),
        .dbell_err      (dbell_err),
        .cq_full        (cq_full),
        .cq_empty       (cq_empty),
        .cq_irq         (cq_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_entries(input logic [31:0] dw3);
        for (int i = 0; i < int'(N); i++) begin
            req_entry[128*i +: 128] = {dw3, low_bits};
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        cq_enable      = '0;
        req_valid      = '0;
        cq_write_ack   = 1'b0;
        cq_dbell_valid = 1'b0;
        cq_dbell_id    = '0;
        cq_dbell_ptr   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One complete post with cq_write_ack held high: grant, write cycle, irq pulse.
    task automatic post(input int q, input logic [63:0] addr, input logic [31:0] dw3);
        logic [N-1:0] oh;
        oh = N'(1 << q);
        #1;
        chk("grant", 128'(req_ready), 128'(oh));
        @(negedge clk);
        chk("write_req", 128'(cq_write_req), 128'(1'b1));
        chk("write_id", 128'(cq_write_id), 128'(q));
        chk("write_addr", 128'(cq_write_addr), 128'(addr));
        chk("write_data", cq_write_data, {dw3, low_bits});
        @(negedge clk);
        chk("irq", 128'(cq_irq), 128'(oh));
    endtask

    task automatic doorbell(input logic [31:0] id, input logic [31:0] ptr, input logic exp_err);
        cq_dbell_valid = 1'b1;
        cq_dbell_id    = id;
        cq_dbell_ptr   = ptr;
        @(negedge clk);
        cq_dbell_valid = 1'b0;
        chk("dbell_ack", 128'(cq_dbell_ack), 128'(1'b1));
        chk("dbell_err", 128'(dbell_err), 128'(exp_err));
    endtask

    initial begin
        cq_base_addr = {64'h4000, 64'h3000, 64'h2000, 64'h1000};
        req_entry    = '0;

        // Reset values, sampled while reset is still asserted
        reset          = 1'b1;
        cq_enable      = '0;
        req_valid      = '0;
        cq_write_ack   = 1'b0;
        cq_dbell_valid = 1'b0;
        cq_dbell_id    = '0;
        cq_dbell_ptr   = '0;
        repeat (2) @(negedge clk);
        chk("rst_write_req", 128'(cq_write_req), 128'(1'b0));
        chk("rst_req_ready", 128'(req_ready), 128'(4'h0));
        chk("rst_empty", 128'(cq_empty), 128'(4'hF));
        chk("rst_full", 128'(cq_full), 128'(4'h0));
        chk("rst_irq", 128'(cq_irq), 128'(4'h0));
        chk("rst_dbell", 128'({cq_dbell_ack, dbell_err}), 128'(2'b00));
        reset = 1'b0;

        // Single post on q0: phase bit forced to 1 over an entry that has it clear
        cq_enable    = 4'b0001;
        set_entries(32'hDEAC_BEEF);
        req_valid    = 4'b0001;
        cq_write_ack = 1'b1;
        post(0, 64'h1000, 32'hDEAD_BEEF);
        req_valid    = '0;
        cq_write_ack = 1'b0;
        chk("t1_empty", 128'(cq_empty), 128'(4'hE));
        @(negedge clk);
        chk("t1_irq_cleared", 128'(cq_irq), 128'(4'h0));

        // Round robin among queues 0..2 with immediate acks
        do_reset();
        cq_enable    = 4'b0111;
        set_entries(32'hDEAD_BEEF);
        req_valid    = 4'b0111;
        cq_write_ack = 1'b1;
        post(0, 64'h1000, 32'hDEAD_BEEF);
        post(1, 64'h2000, 32'hDEAD_BEEF);
        post(2, 64'h3000, 32'hDEAD_BEEF);
        post(0, 64'h1010, 32'hDEAD_BEEF);
        post(1, 64'h2010, 32'hDEAD_BEEF);
        post(2, 64'h3010, 32'hDEAD_BEEF);
        req_valid    = '0;
        cq_write_ack = 1'b0;
        chk("t2_empty", 128'(cq_empty), 128'(4'b1000));

        // Fill q0 (depth 4 holds 3), stall, free space with a doorbell, wrap the tail
        do_reset();
        cq_enable    = 4'b0001;
        req_valid    = 4'b0001;
        cq_write_ack = 1'b1;
        post(0, 64'h1000, 32'hDEAD_BEEF);
        post(0, 64'h1010, 32'hDEAD_BEEF);
        post(0, 64'h1020, 32'hDEAD_BEEF);
        chk("t3_full", 128'(cq_full), 128'(4'b0001));
        #1;
        chk("t3_stall_ready", 128'(req_ready), 128'(4'h0));
        @(negedge clk);
        chk("t3_stall_wreq", 128'(cq_write_req), 128'(1'b0));
        doorbell(0, 2, 1'b0);
        chk("t3_not_full", 128'(cq_full), 128'(4'h0));
        post(0, 64'h1030, 32'hDEAD_BEEF);
        // Tail wrapped to 0: next entry lands at the base with phase 0
        post(0, 64'h1000, 32'hDEAC_BEEF);
        req_valid    = '0;
        cq_write_ack = 1'b0;
        chk("t4_full", 128'(cq_full), 128'(4'b0001));

        // Invalid doorbells: bad id, bad pointer, disabled queue
        doorbell(N, 0, 1'b1);
        doorbell(0, D, 1'b1);
        doorbell(1, 0, 1'b1);
        @(negedge clk);
        chk("t5_ack_low", 128'({cq_dbell_ack, dbell_err}), 128'(2'b00));
        chk("t5_full_kept", 128'(cq_full), 128'(4'b0001));
        chk("t5_empty_kept", 128'(cq_empty), 128'(4'b1110));

        // Disable q0 while its write waits for ack (q0 has phase 0, tail 1 beforehand)
        do_reset();
        cq_enable    = 4'b0001;
        req_valid    = 4'b0001;
        cq_write_ack = 1'b1;
        post(0, 64'h1000, 32'hDEAD_BEEF);
        post(0, 64'h1010, 32'hDEAD_BEEF);
        post(0, 64'h1020, 32'hDEAD_BEEF);
        doorbell(0, 3, 1'b0);
        post(0, 64'h1030, 32'hDEAD_BEEF);
        post(0, 64'h1000, 32'hDEAC_BEEF);
        cq_write_ack = 1'b0;
        #1;
        chk("t6_grant", 128'(req_ready), 128'(4'b0001));
        @(negedge clk);
        chk("t6_addr", 128'(cq_write_addr), 128'(64'h1010));
        cq_enable = '0;
        req_valid = '0;
        repeat (5) @(negedge clk);
        chk("t6_held", 128'(cq_write_req), 128'(1'b1));
        chk("t6_data_stable", cq_write_data, {32'hDEAC_BEEF, low_bits});
        cq_write_ack = 1'b1;
        @(negedge clk);
        cq_write_ack = 1'b0;
        chk("t6_no_irq", 128'(cq_irq), 128'(4'h0));
        chk("t6_req_low", 128'(cq_write_req), 128'(1'b0));
        @(negedge clk);
        chk("t6_cleared_empty", 128'(cq_empty), 128'(4'hF));
        chk("t6_no_irq_late", 128'(cq_irq), 128'(4'h0));
        // Re-enabled queue restarts at tail 0 with phase 1
        cq_enable    = 4'b0001;
        req_valid    = 4'b0001;
        cq_write_ack = 1'b1;
        post(0, 64'h1000, 32'hDEAD_BEEF);
        req_valid    = '0;
        cq_write_ack = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
